// File: rtl/multi_mode_string_search_processor.sv
// Byte-stream string search: a length-prefixed needle followed by a haystack in one packet,
// answered with a found flag, an overlapping match count or the first-match position.
module multi_mode_string_search_processor #(
   parameter int MAX_NEEDLE_LEN = 40,
   parameter int COUNT_WIDTH    = 16,
   parameter int MODE           = 0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic [7:0] i_in_data,
   input  logic       i_in_valid,
   input  logic       i_in_last,
   output logic       o_in_ready,
   output logic [7:0] o_out_data,
   output logic       o_out_valid,
   output logic       o_out_last,
   input  logic       i_out_ready
);
   localparam int RESULT_BYTES = (COUNT_WIDTH + 7) / 8;
   localparam int OUT_BYTES    = (MODE == 0) ? 1 : RESULT_BYTES;
   localparam int RES_W        = RESULT_BYTES * 8;
   localparam int LW           = $clog2(MAX_NEEDLE_LEN + 1);
   localparam int BW           = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
   localparam int CW1          = COUNT_WIDTH + 1;

   typedef enum logic [1:0] {S_LEN, S_NEEDLE, S_HAY, S_EMIT} state_t;
   state_t r_state, w_state_next;

   logic [7:0]             r_needle [MAX_NEEDLE_LEN];
   logic [7:0]             r_window [MAX_NEEDLE_LEN-1];
   logic [7:0]             w_cur    [MAX_NEEDLE_LEN];
   logic [LW-1:0]          r_n;
   logic [7:0]             r_l, r_k;
   logic [COUNT_WIDTH-1:0] r_count, r_hay_idx, r_first;
   logic [COUNT_WIDTH-1:0] w_count_next, w_first_next;
   logic [BW-1:0]          r_byte_idx;
   logic [7:0]             r_out_data;
   logic                   r_out_valid, r_out_last;
   logic                   w_accept, w_send, w_eq_all, w_match;
   logic [RES_W-1:0]       w_res;

   assign o_in_ready  = i_enable & i_rst_n & (r_state != S_EMIT);
   assign w_accept    = o_in_ready & i_in_valid;
   assign w_send      = i_enable & r_out_valid & i_out_ready;
   assign o_out_data  = r_out_data;
   assign o_out_valid = r_out_valid;
   assign o_out_last  = r_out_last;

   // w_cur[d] is the byte d positions back from the incoming one
   assign w_cur[0] = i_in_data;
   generate
      for (genvar gi = 1; gi < MAX_NEEDLE_LEN; gi++) begin : g_cur
         assign w_cur[gi] = r_window[gi-1];
      end
   endgenerate

   always_comb begin
      w_eq_all = 1'b1;
      for (int j = 0; j < MAX_NEEDLE_LEN; j++) begin
         if (LW'(j) < r_n) begin
            if (r_needle[j] != w_cur[r_n - LW'(j) - LW'(1)]) w_eq_all = 1'b0;
         end
      end
   end

   assign w_match = (r_state == S_HAY) & w_accept & (r_n != '0) & w_eq_all &
                    (CW1'(r_hay_idx) + CW1'(1) >= CW1'(r_n));

   // first-match position is reported 1-based (the haystack's first byte is position 1)
   always_comb begin
      w_count_next = r_count;
      w_first_next = r_first;
      if (w_match) begin
         if (r_count != '1) w_count_next = r_count + COUNT_WIDTH'(1);
         if (r_count == '0) w_first_next = r_hay_idx + COUNT_WIDTH'(2) - COUNT_WIDTH'(r_n);
      end
   end

   always_comb begin
      if (MODE == 0)      w_res = RES_W'(w_count_next != '0);
      else if (MODE == 1) w_res = RES_W'(w_count_next);
      else                w_res = RES_W'(w_first_next);
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_LEN: if (w_accept) begin
            if (i_in_last)              w_state_next = S_EMIT;
            else if (i_in_data == 8'd0) w_state_next = S_HAY;
            else                        w_state_next = S_NEEDLE;
         end
         S_NEEDLE: if (w_accept) begin
            if (i_in_last)               w_state_next = S_EMIT;
            else if (r_k + 8'd1 == r_l)  w_state_next = S_HAY;
         end
         S_HAY:   if (w_accept && i_in_last)  w_state_next = S_EMIT;
         S_EMIT:  if (w_send && r_out_last)   w_state_next = S_LEN;
         default: w_state_next = S_LEN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      r_state <= S_LEN;
      else if (i_enable) r_state <= w_state_next;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_l         <= '0;
         r_k         <= '0;
         r_n         <= '0;
         r_count     <= '0;
         r_hay_idx   <= '0;
         r_first     <= '1;
         r_byte_idx  <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         for (int i = 0; i < MAX_NEEDLE_LEN; i++)     r_needle[i] <= '0;
         for (int i = 0; i < MAX_NEEDLE_LEN - 1; i++) r_window[i] <= '0;
      end else if (i_enable) begin
         if (w_accept) begin
            case (r_state)
               S_LEN: begin
                  r_l <= i_in_data;
                  r_k <= '0;
                  r_n <= (int'(i_in_data) > MAX_NEEDLE_LEN) ? LW'(MAX_NEEDLE_LEN) : LW'(i_in_data);
               end
               S_NEEDLE: begin
                  if (r_k < 8'(r_n)) r_needle[r_k[LW-1:0]] <= i_in_data;
                  r_k <= r_k + 8'd1;
               end
               S_HAY: begin
                  r_window[0] <= i_in_data;
                  for (int i = 1; i < MAX_NEEDLE_LEN - 1; i++) r_window[i] <= r_window[i-1];
                  if (r_hay_idx != '1) r_hay_idx <= r_hay_idx + COUNT_WIDTH'(1);
                  r_count <= w_count_next;
                  r_first <= w_first_next;
               end
               default: ;
            endcase
            if (i_in_last) begin
               r_out_data  <= w_res[7:0];
               r_out_valid <= 1'b1;
               r_out_last  <= (OUT_BYTES == 1);
               r_byte_idx  <= '0;
            end
         end else if (w_send) begin
            if (r_out_last) begin
               // result fully delivered: wipe per-packet state for the next packet
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
               r_out_data  <= '0;
               r_count     <= '0;
               r_hay_idx   <= '0;
               r_first     <= '1;
               r_n         <= '0;
               for (int i = 0; i < MAX_NEEDLE_LEN - 1; i++) r_window[i] <= '0;
            end else begin
               r_byte_idx <= r_byte_idx + BW'(1);
               r_out_data <= w_res[8*(int'(r_byte_idx)+1) +: 8];
               r_out_last <= (int'(r_byte_idx) + 2 == OUT_BYTES);
            end
         end
      end
   end
endmodule
